// File: rtl/dino_renderer_pkg.sv
// Shared constants for the dino renderer: VGA timing, sprite geometry, screen placement,
// colours, dino animation state codes and the sprite art used by the sprite ROM.
package dino_renderer_pkg;

    // 640x480@60 VGA timing
    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 752;
    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned V_TOTAL      = 525;
    localparam int unsigned V_SYNC_START = 490;
    localparam int unsigned V_SYNC_END   = 492;

    // Sprite geometry; the ROM address layout below assumes these sizes
    localparam int unsigned DINO_W = 32;
    localparam int unsigned DINO_H = 32;
    localparam int unsigned OBS_W  = 16;
    localparam int unsigned OBS_H  = 32;

    // Screen placement
    localparam int unsigned GROUND_SCREEN_Y = 40;  // ground height above the bottom row
    localparam int unsigned DINO_SCREEN_X   = 64;  // left column of the dino box
    localparam int unsigned OBS_CENTER_X    = 8;   // obstacle_x minus this is its left column

    localparam logic [11:0] FG_RGB      = 12'h555;
    localparam logic [11:0] BG_RGB      = 12'hFFF;
    localparam logic [11:0] OVER_BG_RGB = 12'hFCC;

    typedef enum logic [1:0] {
        DINO_STATE_RUN_1    = 2'd0,
        DINO_STATE_RUN_2    = 2'd1,
        DINO_STATE_JUMP     = 2'd2,
        DINO_STATE_COLLIDED = 2'd3
    } dino_state_e;

    // ROM map: dino frames at {0, state[1:0], row[4:0], col[4:0]},
    // obstacle at {1, 3'b000, row[4:0], col[3:0]}.
    localparam int unsigned ROM_AW = 13;

    // Sprite art, one bit per pixel; row 0 is the top row of the sprite.
    function automatic logic sprite_bit(input logic [ROM_AW-1:0] addr);
        int unsigned row;
        int unsigned col;
        int unsigned frame;
        if (addr[12]) begin
            row = 32'(addr[8:4]);
            col = 32'(addr[3:0]);
            return ((row + 2 * col) % 5) != 0;
        end
        frame = 32'(addr[11:10]);
        row   = 32'(addr[9:5]);
        col   = 32'(addr[4:0]);
        return ((3 * row + col + 5 * frame) % 7) != 0;
    endfunction

endpackage

// File: rtl/dino_sprite_rom.sv
// 1-bpp synchronous sprite ROM: four 32x32 dino frames plus one 16x32 obstacle.
// Contents come from sprite_bit() so synthesis folds them into a constant table.
// Ports:
//   clk  - read clock
//   addr - ROM address (layout in dino_renderer_pkg)
//   data - pixel bit, valid one cycle after addr
module dino_sprite_rom
    import dino_renderer_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic              data
);

    always_ff @(posedge clk) begin
        data <= sprite_bit(addr);
    end

endmodule

// File: rtl/dino_renderer.sv
// VGA timing generator and rasteriser for the dino game.
// Snapshots the game state once per frame and draws ground, obstacle and dino.
// Ports:
//   pix_clk, rst_n        - pixel clock, async active-low reset
//   dino_y, obstacle_x    - dino feet height (y up), obstacle centre column
//   dino_state, game_over - animation frame select, game ended
//   frame_tick            - one-cycle pulse at start of vertical blanking
//   hsync, vsync, rgb     - VGA outputs, 3-cycle latency from the counters
module dino_renderer #(
    parameter int unsigned H_ACTIVE     = dino_renderer_pkg::H_ACTIVE,
    parameter int unsigned H_TOTAL      = dino_renderer_pkg::H_TOTAL,
    parameter int unsigned H_SYNC_START = dino_renderer_pkg::H_SYNC_START,
    parameter int unsigned H_SYNC_END   = dino_renderer_pkg::H_SYNC_END,
    parameter int unsigned V_ACTIVE     = dino_renderer_pkg::V_ACTIVE,
    parameter int unsigned V_TOTAL      = dino_renderer_pkg::V_TOTAL,
    parameter int unsigned V_SYNC_START = dino_renderer_pkg::V_SYNC_START,
    parameter int unsigned V_SYNC_END   = dino_renderer_pkg::V_SYNC_END
) (
    input  logic        pix_clk,
    input  logic        rst_n,
    input  logic [11:0] dino_y,
    input  logic [11:0] obstacle_x,
    input  logic [1:0]  dino_state,
    input  logic        game_over,
    output logic        frame_tick,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);
    import dino_renderer_pkg::*;

    localparam int unsigned CW = 10;

    // Screen-space constants in the 13-bit signed coordinate domain
    localparam logic signed [12:0] DINO_X     = 13'(DINO_SCREEN_X);
    localparam logic signed [12:0] DINO_XE    = 13'(DINO_SCREEN_X + DINO_W);
    localparam logic signed [12:0] V_LAST     = 13'(V_ACTIVE - 1);
    localparam logic signed [12:0] GROUND_ROW = 13'(V_ACTIVE - 1 - GROUND_SCREEN_Y);
    localparam logic signed [12:0] OBS_TOP    = 13'(V_ACTIVE - GROUND_SCREEN_Y - OBS_H);
    localparam logic signed [12:0] OBS_CX     = 13'(OBS_CENTER_X);
    localparam logic signed [12:0] OBS_WS     = 13'(OBS_W);
    localparam logic signed [12:0] DINO_HM1   = 13'(DINO_H - 1);

    logic [CW-1:0] h_q, v_q;
    logic          h_wrap;
    logic          snap_en;

    logic [11:0]   snap_dino_y, snap_obs_x;
    dino_state_e   snap_state;
    logic          snap_over;

    assign h_wrap     = (h_q == CW'(H_TOTAL - 1));
    assign frame_tick = (h_q == '0) && (v_q == CW'(V_ACTIVE));
    assign snap_en    = (h_q == '0) && (v_q == CW'(V_TOTAL - 1));

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_wrap) begin
            h_q <= '0;
            v_q <= (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
        end else begin
            h_q <= h_q + 1'b1;
        end
    end

    // Taken during the last blanking line so the whole visible frame sees one state
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_dino_y <= '0;
            snap_obs_x  <= '0;
            snap_state  <= DINO_STATE_RUN_1;
            snap_over   <= 1'b0;
        end else if (snap_en) begin
            snap_dino_y <= dino_y;
            snap_obs_x  <= obstacle_x;
            snap_state  <= dino_state_e'(dino_state);
            snap_over   <= game_over;
        end
    end

    // Stage 1: box hits and ROM addresses. Offsets are only used inside a hit, so any
    // wrap in their truncated forms is harmless; hit tests use full-width compares.
    logic signed [12:0] h_s, v_s, feet_row, dino_top, obs_left, obs_col;
    logic [4:0]         dino_row, dino_col, obs_row;
    logic               dino_hit, obs_hit, active, hs_c, vs_c;

    always_comb begin
        h_s      = $signed({3'b000, h_q});
        v_s      = $signed({3'b000, v_q});
        feet_row = V_LAST - $signed({1'b0, snap_dino_y});
        dino_top = feet_row - DINO_HM1;
        obs_left = $signed({1'b0, snap_obs_x}) - OBS_CX;
        obs_col  = h_s - obs_left;
        dino_row = 5'(v_s - dino_top);
        dino_col = 5'(h_s - DINO_X);
        obs_row  = 5'(v_s - OBS_TOP);
        dino_hit = (h_s >= DINO_X) && (h_s < DINO_XE) && (v_s >= dino_top) && (v_s <= feet_row);
        obs_hit  = (obs_col >= 13'sd0) && (obs_col < OBS_WS)
                   && (v_s >= OBS_TOP) && (v_s <= GROUND_ROW);
        active   = (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
        hs_c     = !((h_q >= CW'(H_SYNC_START)) && (h_q < CW'(H_SYNC_END)));
        vs_c     = !((v_q >= CW'(V_SYNC_START)) && (v_q < CW'(V_SYNC_END)));
    end

    logic              s1_dino_hit, s1_obs_hit, s1_ground, s1_active, s1_hs, s1_vs;
    logic [ROM_AW-1:0] s1_dino_addr, s1_obs_addr;
    logic              s2_dino_hit, s2_obs_hit, s2_ground, s2_active, s2_hs, s2_vs;
    logic              dino_bit, obs_bit;
    logic [11:0]       rgb_q;
    logic              hs_q, vs_q;

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_dino_hit  <= 1'b0;
            s1_obs_hit   <= 1'b0;
            s1_ground    <= 1'b0;
            s1_active    <= 1'b0;
            s1_hs        <= 1'b1;
            s1_vs        <= 1'b1;
            s1_dino_addr <= '0;
            s1_obs_addr  <= '0;
            s2_dino_hit  <= 1'b0;
            s2_obs_hit   <= 1'b0;
            s2_ground    <= 1'b0;
            s2_active    <= 1'b0;
            s2_hs        <= 1'b1;
            s2_vs        <= 1'b1;
            rgb_q        <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
        end else begin
            s1_dino_hit  <= dino_hit;
            s1_obs_hit   <= obs_hit;
            s1_ground    <= (v_s == GROUND_ROW);
            s1_active    <= active;
            s1_hs        <= hs_c;
            s1_vs        <= vs_c;
            s1_dino_addr <= {1'b0, snap_state, dino_row, dino_col};
            s1_obs_addr  <= {1'b1, 3'b000, obs_row, obs_col[3:0]};
            s2_dino_hit  <= s1_dino_hit;
            s2_obs_hit   <= s1_obs_hit;
            s2_ground    <= s1_ground;
            s2_active    <= s1_active;
            s2_hs        <= s1_hs;
            s2_vs        <= s1_vs;
            hs_q         <= s2_hs;
            vs_q         <= s2_vs;
            if (!s2_active) begin
                rgb_q <= '0;
            end else if ((s2_dino_hit && dino_bit) || (s2_obs_hit && obs_bit) || s2_ground) begin
                rgb_q <= FG_RGB;
            end else begin
                rgb_q <= snap_over ? OVER_BG_RGB : BG_RGB;
            end
        end
    end

    // Two read ports of the same art so an obstacle pixel still shows through a
    // transparent dino pixel where the boxes overlap.
    dino_sprite_rom u_dino_rom (
        .clk  (pix_clk),
        .addr (s1_dino_addr),
        .data (dino_bit)
    );

    dino_sprite_rom u_obs_rom (
        .clk  (pix_clk),
        .addr (s1_obs_addr),
        .data (obs_bit)
    );

    assign rgb   = rgb_q;
    assign hsync = hs_q;
    assign vsync = vs_q;

endmodule

// File: tb/tb_dino_renderer.sv
// Randomised self-checking bench for dino_renderer, run with a reduced VGA raster so
// several whole frames fit in a short simulation.
module tb_dino_renderer;

    localparam int HA = 96, HT = 120, HSS = 100, HSE = 112;
    localparam int VA = 80, VT = 88,  VSS = 82,  VSE = 84;
    localparam int FRAME = HT * VT;
    localparam int NCYC  = 6 * FRAME + 5;
    localparam int GY = 40, DX = 64, OCX = 8;
    localparam int DW = 32, DH = 32, OW = 16, OH = 32;
    localparam logic [11:0] FG = 12'h555, BG = 12'hFFF, OBG = 12'hFCC;

    logic        pix_clk = 1'b0;
    logic        rst_n;
    logic [11:0] dino_y, obstacle_x;
    logic [1:0]  dino_state;
    logic        game_over;
    logic        frame_tick, hsync, vsync;
    logic [11:0] rgb;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_k   = -1;

    // Reference snapshot of the game state for the frame being drawn
    int snap_dy, snap_ox, snap_st;
    bit snap_go;

    dino_renderer #(
        .H_ACTIVE     (HA),
        .H_TOTAL      (HT),
        .H_SYNC_START (HSS),
        .H_SYNC_END   (HSE),
        .V_ACTIVE     (VA),
        .V_TOTAL      (VT),
        .V_SYNC_START (VSS),
        .V_SYNC_END   (VSE)
    ) dut (
        .pix_clk    (pix_clk),
        .rst_n      (rst_n),
        .dino_y     (dino_y),
        .obstacle_x (obstacle_x),
        .dino_state (dino_state),
        .game_over  (game_over),
        .frame_tick (frame_tick),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb)
    );

    always #20 pix_clk = ~pix_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cur_k, got, exp);
        end
    endtask

    // Sprite art as drawn by the game's artist: row 0 at the top of each sprite
    function automatic bit dino_art(input int st, input int row, input int col);
        return ((3 * row + col + 5 * st) % 7) != 0;
    endfunction

    function automatic bit obs_art(input int row, input int col);
        return ((row + 2 * col) % 5) != 0;
    endfunction

    function automatic logic [11:0] ref_pixel(input int h, input int v);
        int feet, top, gr, otop, oleft;
        bit set;
        if (h >= HA || v >= VA) return 12'h000;
        feet  = VA - 1 - snap_dy;
        top   = feet - DH + 1;
        gr    = VA - 1 - GY;
        otop  = gr - OH + 1;
        oleft = snap_ox - OCX;
        set   = 1'b0;
        if (h >= DX && h < DX + DW && v >= top && v <= feet)
            set = set | dino_art(snap_st, v - top, h - DX);
        if (h >= oleft && h < oleft + OW && v >= otop && v <= gr)
            set = set | obs_art(v - otop, h - oleft);
        if (set || v == gr) return FG;
        return snap_go ? OBG : BG;
    endfunction

    task automatic random_inputs();
        dino_y     = 12'($urandom);
        obstacle_x = 12'($urandom);
        dino_state = 2'($urandom);
        game_over  = 1'($urandom);
    endtask

    // Game state intended for frame n, applied right after frame_tick
    task automatic plan_frame(input int n);
        case (n)
            1: begin dino_y = 12'(GY); dino_state = 2'd0; obstacle_x = 12'd60; game_over = 1'b0; end
            2: begin
                dino_y = 12'(GY + 20); dino_state = 2'($urandom);
                obstacle_x = 12'd30; game_over = 1'b0;
            end
            3: begin
                dino_y = 12'($urandom_range(0, 60)); dino_state = 2'($urandom);
                obstacle_x = 12'd4; game_over = 1'b1;
            end
            4: begin
                dino_y = 12'($urandom_range(0, 100)); dino_state = 2'($urandom);
                obstacle_x = 12'($urandom_range(0, HA + 20)); game_over = 1'b0;
            end
            default: random_inputs();
        endcase
    endtask

    initial begin
        int last_tick, ticks, ticks_exp, hs_fall, vs_fall, hs_seen;
        logic prev_hs, prev_vs;
        last_tick = -1; ticks = 0; ticks_exp = 0; hs_fall = -1; vs_fall = -1; hs_seen = 0;

        rst_n = 1'b1;
        random_inputs();
        #5 rst_n = 1'b0;
        repeat (10) begin
            @(negedge pix_clk);
            check("reset_outputs", 32'({frame_tick, hsync, vsync, rgb}), 32'({3'b011, 12'h000}));
        end
        rst_n = 1'b1;
        snap_dy = 0; snap_ox = 0; snap_st = 0; snap_go = 1'b0;
        prev_hs = hsync; prev_vs = vsync;

        for (int k = 0; k < NCYC; k++) begin
            int h, v, hj, vj;
            logic [14:0] exp_v;
            cur_k = k;
            h = k % HT;
            v = (k / HT) % VT;
            exp_v[14] = (h == 0 && v == VA);
            if (k < 3) begin
                exp_v[13:0] = {2'b11, 12'h000};
            end else begin
                hj = (k - 3) % HT;
                vj = ((k - 3) / HT) % VT;
                exp_v[13]   = !(hj >= HSS && hj < HSE);
                exp_v[12]   = !(vj >= VSS && vj < VSE);
                exp_v[11:0] = ref_pixel(hj, vj);
            end
            check("pixel", 32'({frame_tick, hsync, vsync, rgb}), 32'(exp_v));

            if (exp_v[14]) ticks_exp++;
            if (frame_tick) begin
                if (last_tick >= 0) check("tick_interval", 32'(k - last_tick), 32'(FRAME));
                last_tick = k;
                ticks++;
            end
            if (prev_hs && !hsync) begin
                hs_fall = k;
                if (hs_seen == 0) check("first_hsync_low", 32'(k), 32'(HSS + 3));
                hs_seen = 1;
            end
            if (!prev_hs && hsync && hs_fall >= 0) check("hsync_width", 32'(k - hs_fall), 32'(HSE - HSS));
            if (prev_vs && !vsync) vs_fall = k;
            if (!prev_vs && vsync && vs_fall >= 0)
                check("vsync_width", 32'(k - vs_fall), 32'((VSE - VSS) * HT));
            prev_hs = hsync;
            prev_vs = vsync;

            // Mid-frame noise must not reach the frame on screen
            if (h == 0 && v == 20) random_inputs();
            if (h == 0 && v == VA) plan_frame(k / FRAME + 1);
            if (h == 0 && v == VT - 1) begin
                snap_dy = int'(dino_y);
                snap_ox = int'(obstacle_x);
                snap_st = int'(dino_state);
                snap_go = game_over;
            end
            @(negedge pix_clk);
        end

        check("tick_count", 32'(ticks), 32'(ticks_exp));
        check("hsync_seen", 32'(hs_seen), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
